// File: rtl/power_monitor_fault_qualifier_if.sv
// Signal bundle between the power-monitor base block / firmware and the fault qualifier.
// The master side drives the monitor and firmware inputs; the qualifier is the slave.
interface power_monitor_fault_qualifier_if;
    logic [31:0] pgood_in;
    logic        fault_in;
    logic        warn_in;
    logic        eoc_in;
    logic        enable;
    logic        clear;
    logic [31:0] pgood_q;
    logic        all_good;
    logic        warn_active;
    logic        fault_latched;
    logic        shutdown;
    logic [1:0]  fault_cause;
    logic        irq;
    logic [1:0]  state;

    modport master (
        output pgood_in, fault_in, warn_in, eoc_in, enable, clear,
        input  pgood_q, all_good, warn_active, fault_latched, shutdown,
               fault_cause, irq, state
    );

    modport slave (
        input  pgood_in, fault_in, warn_in, eoc_in, enable, clear,
        output pgood_q, all_good, warn_active, fault_latched, shutdown,
               fault_cause, irq, state
    );
endinterface

// File: rtl/power_monitor_fault_qualifier.sv
// Debounces per-converter power-good, escalates repeated warnings and latches faults
// with a cause code, a sticky shutdown request and a one-cycle interrupt.
module power_monitor_fault_qualifier #(
    parameter int NumConverters    = 8,
    parameter int DebounceCycles   = 4,
    parameter int WarnToFaultCount = 3
) (
    input  logic                           clock,
    input  logic                           reset_n,
    power_monitor_fault_qualifier_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MONITOR = 2'b01,
        WARN    = 2'b10,
        FAULT   = 2'b11
    } state_e;

    localparam logic [1:0] CauseNone  = 2'b00;
    localparam logic [1:0] CauseExt   = 2'b01;
    localparam logic [1:0] CauseWarn  = 2'b10;
    localparam logic [1:0] CausePgood = 2'b11;

    localparam logic [31:0] ActiveMask = (NumConverters >= 32) ? 32'hFFFF_FFFF
                                       : ((32'd1 << NumConverters) - 32'd1);
    localparam logic [7:0]  DebLast    = 8'(DebounceCycles - 1);
    localparam logic [3:0]  WarnLimit  = 4'(WarnToFaultCount);

    logic [31:0] pgood_deb_q, pgood_deb_d;
    logic [7:0]  deb_cnt_q [32];
    logic [7:0]  deb_cnt_d [32];
    logic        all_good_q, all_good_d;
    state_e      state_q, state_d;
    logic [1:0]  cause_q, cause_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  wcnt_inc;
    logic        arm_q, arm_d;
    logic        irq_q, irq_d;

    // Inactive bits are pinned low so they can never mask a loss on a real converter.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            pgood_deb_d[i] = pgood_deb_q[i];
            deb_cnt_d[i]   = deb_cnt_q[i];
            if (!ActiveMask[i]) begin
                pgood_deb_d[i] = 1'b0;
                deb_cnt_d[i]   = 8'd0;
            end else if (bus.pgood_in[i] == pgood_deb_q[i]) begin
                deb_cnt_d[i] = 8'd0;
            end else if (deb_cnt_q[i] == DebLast) begin
                pgood_deb_d[i] = bus.pgood_in[i];
                deb_cnt_d[i]   = 8'd0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
            end
        end
    end

    assign all_good_d = &(pgood_deb_q | ~ActiveMask);
    assign wcnt_inc   = wcnt_q + 4'd1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pgood_deb_q <= '0;
            for (int i = 0; i < 32; i++) deb_cnt_q[i] <= '0;
            all_good_q  <= 1'b0;
            state_q     <= IDLE;
            cause_q     <= CauseNone;
            wcnt_q      <= '0;
            arm_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            pgood_deb_q <= pgood_deb_d;
            for (int i = 0; i < 32; i++) deb_cnt_q[i] <= deb_cnt_d[i];
            all_good_q  <= all_good_d;
            state_q     <= state_d;
            cause_q     <= cause_d;
            wcnt_q      <= wcnt_d;
            arm_q       <= arm_d;
            irq_q       <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        wcnt_d  = wcnt_q;
        arm_d   = arm_q;
        case (state_q)
            IDLE: begin
                if (bus.enable) state_d = MONITOR;
            end
            MONITOR, WARN: begin
                if (all_good_q) arm_d = 1'b1;
                if (!bus.enable) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    arm_d   = 1'b0;
                end else if (bus.fault_in) begin
                    state_d = FAULT;
                    cause_d = CauseExt;
                end else if (arm_q && !all_good_q) begin
                    state_d = FAULT;
                    cause_d = CausePgood;
                end else if (bus.eoc_in && bus.warn_in) begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc >= WarnLimit) begin
                        state_d = FAULT;
                        cause_d = CauseWarn;
                    end else begin
                        state_d = WARN;
                    end
                end else if (bus.eoc_in) begin
                    wcnt_d  = '0;
                    state_d = MONITOR;
                end
            end
            default: begin
                // A clear seen while the fault is still asserted is dropped, not queued.
                if (bus.clear && !bus.fault_in) begin
                    state_d = bus.enable ? MONITOR : IDLE;
                    cause_d = CauseNone;
                    wcnt_d  = '0;
                    arm_d   = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        irq_d = (state_d != state_q) && ((state_d == WARN) || (state_d == FAULT));
    end

    assign bus.pgood_q       = pgood_deb_q;
    assign bus.all_good      = all_good_q;
    assign bus.warn_active   = (state_q == WARN);
    assign bus.fault_latched = (state_q == FAULT);
    assign bus.shutdown      = (state_q == FAULT);
    assign bus.fault_cause   = cause_q;
    assign bus.irq           = irq_q;
    assign bus.state         = state_q;
endmodule

// File: tb/tb_power_monitor_fault_qualifier.sv
// Directed bench for the power-monitor fault qualifier with hand-computed expectations.
module tb_power_monitor_fault_qualifier;
    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errs;

    power_monitor_fault_qualifier_if bus ();

    power_monitor_fault_qualifier #(
        .NumConverters   (8),
        .DebounceCycles  (4),
        .WarnToFaultCount(3)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic eoc_pulse(input logic warn);
        bus.warn_in = warn;
        bus.eoc_in  = 1'b1;
        step(1);
        bus.eoc_in  = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errs   = 0;
        reset_n      = 1'b0;
        bus.pgood_in = '0;
        bus.fault_in = 1'b0;
        bus.warn_in  = 1'b0;
        bus.eoc_in   = 1'b0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;
        #3;
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_shutdown", 32'(bus.shutdown), 32'd0);
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_pgood", bus.pgood_q, 32'd0);
        check("rst_cause", 32'(bus.fault_cause), 32'd0);
        #1 reset_n = 1'b1;
        step(1);

        // Enable: IDLE -> MONITOR
        bus.enable = 1'b1;
        step(1);
        check("en_state", 32'(bus.state), 32'd1);
        check("en_irq", 32'(bus.irq), 32'd0);
        check("en_fault", 32'(bus.fault_latched), 32'd0);

        // Bits 1..7 settle after 4 edges; bits above NumConverters stay 0
        bus.pgood_in = 32'hFFFF_FFFE;
        step(3);
        check("deb_3clk", bus.pgood_q, 32'h0000_0000);
        step(1);
        check("deb_4clk", bus.pgood_q, 32'h0000_00FE);
        check("deb_ag0", 32'(bus.all_good), 32'd0);

        // Glitch on bit 0 shorter than DebounceCycles
        bus.pgood_in = 32'hFFFF_FFFF;
        step(3);
        bus.pgood_in = 32'hFFFF_FFFE;
        step(1);
        check("glitch_a", bus.pgood_q, 32'h0000_00FE);
        step(3);
        check("glitch_b", bus.pgood_q, 32'h0000_00FE);

        // Steady change on bit 0
        bus.pgood_in = 32'hFFFF_FFFF;
        step(3);
        check("hold_3", bus.pgood_q, 32'h0000_00FE);
        step(1);
        check("hold_4", bus.pgood_q, 32'h0000_00FF);
        check("hold_ag_lag", 32'(bus.all_good), 32'd0);
        step(1);
        check("hold_ag", 32'(bus.all_good), 32'd1);
        check("hold_state", 32'(bus.state), 32'd1);

        // Warn escalation over three warned frames
        eoc_pulse(1'b1);
        check("w1_state", 32'(bus.state), 32'd2);
        check("w1_irq", 32'(bus.irq), 32'd1);
        check("w1_active", 32'(bus.warn_active), 32'd1);
        step(1);
        check("w1_irq_off", 32'(bus.irq), 32'd0);
        eoc_pulse(1'b1);
        check("w2_state", 32'(bus.state), 32'd2);
        check("w2_irq", 32'(bus.irq), 32'd0);
        step(2);
        check("w_noeoc", 32'(bus.state), 32'd2);
        eoc_pulse(1'b1);
        check("w3_state", 32'(bus.state), 32'd3);
        check("w3_cause", 32'(bus.fault_cause), 32'd2);
        check("w3_shutdown", 32'(bus.shutdown), 32'd1);
        check("w3_irq", 32'(bus.irq), 32'd1);
        check("w3_active", 32'(bus.warn_active), 32'd0);
        step(1);
        check("w3_irq_off", 32'(bus.irq), 32'd0);

        // Clear with enable high returns to MONITOR
        bus.warn_in = 1'b0;
        bus.clear   = 1'b1;
        step(1);
        bus.clear   = 1'b0;
        check("clr_state", 32'(bus.state), 32'd1);
        check("clr_cause", 32'(bus.fault_cause), 32'd0);
        check("clr_shutdown", 32'(bus.shutdown), 32'd0);

        // Un-warned frame resets the escalation count
        eoc_pulse(1'b1);
        check("r1_state", 32'(bus.state), 32'd2);
        eoc_pulse(1'b0);
        check("r2_state", 32'(bus.state), 32'd1);
        eoc_pulse(1'b1);
        eoc_pulse(1'b1);
        check("r4_state", 32'(bus.state), 32'd2);
        eoc_pulse(1'b1);
        check("r5_state", 32'(bus.state), 32'd3);
        bus.warn_in = 1'b0;
        bus.clear   = 1'b1;
        step(1);
        bus.clear   = 1'b0;
        check("r_clr", 32'(bus.state), 32'd1);
        step(1);

        // Power-good loss on converter 3
        bus.pgood_in = 32'hFFFF_FFF7;
        step(3);
        check("pl_3", bus.pgood_q, 32'h0000_00FF);
        step(1);
        check("pl_4", bus.pgood_q, 32'h0000_00F7);
        check("pl_4_state", 32'(bus.state), 32'd1);
        step(1);
        check("pl_ag", 32'(bus.all_good), 32'd0);
        check("pl_5_state", 32'(bus.state), 32'd1);
        step(1);
        check("pl_state", 32'(bus.state), 32'd3);
        check("pl_cause", 32'(bus.fault_cause), 32'd3);
        check("pl_irq", 32'(bus.irq), 32'd1);

        // Recover pgood while in FAULT, then clear
        bus.pgood_in = 32'hFFFF_FFFF;
        step(5);
        check("rec_ag", 32'(bus.all_good), 32'd1);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        check("rec_state", 32'(bus.state), 32'd1);

        // External fault beats warned frame on the same edge
        bus.fault_in = 1'b1;
        bus.warn_in  = 1'b1;
        bus.eoc_in   = 1'b1;
        step(1);
        bus.warn_in  = 1'b0;
        bus.eoc_in   = 1'b0;
        check("pr_state", 32'(bus.state), 32'd3);
        check("pr_cause", 32'(bus.fault_cause), 32'd1);
        check("pr_irq", 32'(bus.irq), 32'd1);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        check("pr_clr_blocked", 32'(bus.state), 32'd3);
        bus.fault_in = 1'b0;
        step(1);
        check("pr_not_remembered", 32'(bus.state), 32'd3);
        bus.enable = 1'b0;
        step(1);
        check("pr_en_ignored", 32'(bus.state), 32'd3);
        bus.clear = 1'b1;
        step(1);
        bus.clear = 1'b0;
        check("pr_idle", 32'(bus.state), 32'd0);
        check("pr_idle_cause", 32'(bus.fault_cause), 32'd0);
        check("pr_idle_shutdown", 32'(bus.shutdown), 32'd0);

        // IDLE ignores fault_in
        bus.fault_in = 1'b1;
        step(1);
        check("idle_ignore", 32'(bus.state), 32'd0);

        // Async reset while in FAULT
        bus.enable = 1'b1;
        step(1);
        check("ar_mon", 32'(bus.state), 32'd1);
        step(1);
        check("ar_fault", 32'(bus.state), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        check("ar_state", 32'(bus.state), 32'd0);
        check("ar_shutdown", 32'(bus.shutdown), 32'd0);
        check("ar_pgood", bus.pgood_q, 32'd0);
        bus.fault_in = 1'b0;
        bus.enable   = 1'b0;
        #1 reset_n = 1'b1;
        step(1);
        check("ar_after", 32'(bus.state), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
